// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths, sample type and saturation helper for the
//               FIR filter chain and its decimating back end.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int FIR_SAMPLE_W = 16;
    localparam int DEC_OUT_W    = 8;

    typedef logic signed [FIR_SAMPLE_W-1:0] fir_sample_t;

    // Clamp a signed value into the two's-complement range of 'width' bits.
    // The caller detects clipping by comparing the result to the input.
    function automatic logic signed [31:0] sat_to_w(
        input logic signed [31:0] value,
        input int                 width
    );
        logic signed [31:0] w_max;
        logic signed [31:0] w_min;
        w_max = (32'sd1 <<< (width - 1)) - 32'sd1;
        w_min = -(32'sd1 <<< (width - 1));
        if (value > w_max) begin
            return w_max;
        end else if (value < w_min) begin
            return w_min;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_dec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_dec_fifo
// Description : Synchronous FIFO with valid/ready pop. A push into a full
//               FIFO is accepted when a pop happens in the same cycle.
//               When empty, out_data holds the last popped value.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push, push_data   - write request and data
//               push_ok           - push would be accepted this cycle
//               out_valid         - head entry present
//               out_ready         - consumer takes head
//               out_data          - head entry / last popped value
// Revision    : 1.0 - initial release
// ============================================================================
module fir_dec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;

    logic w_full;
    logic w_pop;
    logic w_wr;

    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = out_valid && out_ready;
    assign push_ok   = !w_full || w_pop;
    assign w_wr      = push && push_ok;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : r_last;

    // Storage carries no reset; emptiness is tracked by r_count alone.
    // On full+pop the write lands in the slot being vacated this edge.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : fir_decimator
// Description : Integrate-and-dump decimator behind the 3-tap FIR. Sums
//               blocks of 2^DEC_LOG2 samples, shifts right by
//               DEC_LOG2+SCALE_SH, saturates to OUT_W bits and queues the
//               result in a FIFO with a valid/ready output. Input is never
//               stalled; results arriving at a full FIFO are dropped and
//               counted.
// Options     : FIR_DEC_ROUND_EN - round half-up before the shift instead of
//               truncating (floor).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid, in_data - signed FIR output sample stream
//               out_valid, out_ready, out_data - decimated output handshake
//               sat_flag          - sticky: a result was clipped
//               drop_cnt          - dropped results, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decimator
    import fir_pkg::*;
#(
    parameter int IN_W       = FIR_SAMPLE_W,
    parameter int OUT_W      = DEC_OUT_W,
    parameter int DEC_LOG2   = 2,
    parameter int SCALE_SH   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             sat_flag,
    output logic [7:0]       drop_cnt
);

    // One guard bit above the full block sum keeps the rounding add from wrapping.
    localparam int ACC_W = IN_W + DEC_LOG2 + 1;
    localparam int SHIFT = DEC_LOG2 + SCALE_SH;
    localparam int PH_W  = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;

    logic signed [ACC_W-1:0] r_acc;
    logic [PH_W-1:0]         r_phase;
    logic                    r_sat;
    logic [7:0]              r_drop;

    logic                    w_last;
    logic                    w_dump;
    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_pre;
    logic signed [ACC_W-1:0] w_shr;
    logic signed [31:0]      w_wide;
    logic signed [31:0]      w_clip;
    logic                    w_clipped;
    logic [OUT_W-1:0]        w_result;
    logic                    w_push_ok;

    generate
        if (DEC_LOG2 == 0) begin : g_no_phase
            assign w_last = 1'b1;
        end else begin : g_phase
            assign w_last = (r_phase == PH_W'((1 << DEC_LOG2) - 1));
        end
    endgenerate

    assign w_dump   = in_valid && w_last;
    assign w_in_ext = ACC_W'($signed(in_data));
    assign w_sum    = r_acc + w_in_ext;

    generate
`ifdef FIR_DEC_ROUND_EN
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) <<< (SHIFT - 1);
            assign w_pre = w_sum + HALF_LSB;
        end else begin : g_no_round
            assign w_pre = w_sum;
        end
`else
        if (1) begin : g_trunc
            assign w_pre = w_sum;
        end
`endif
    endgenerate

    // Arithmetic shift of a signed operand floors toward minus infinity.
    assign w_shr     = w_pre >>> SHIFT;
    assign w_wide    = 32'(w_shr);
    assign w_clip    = sat_to_w(w_wide, OUT_W);
    assign w_clipped = (w_clip != w_wide);
    assign w_result  = w_clip[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_phase <= '0;
            r_sat   <= 1'b0;
            r_drop  <= '0;
        end else if (in_valid) begin
            if (w_last) begin
                // Block boundary is kept even when the result is dropped.
                r_acc   <= '0;
                r_phase <= '0;
                if (w_clipped) begin
                    r_sat <= 1'b1;
                end
                if (!w_push_ok && (r_drop != 8'hFF)) begin
                    r_drop <= r_drop + 8'd1;
                end
            end else begin
                r_acc   <= w_sum;
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

    assign sat_flag = r_sat;
    assign drop_cnt = r_drop;

    fir_dec_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_dump),
        .push_data (w_result),
        .push_ok   (w_push_ok),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decimator
// Description : Directed self-checking bench for fir_decimator at default
//               parameters (M=4, S=0, OUT_W=8, FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decimator;

`ifdef FIR_DEC_ROUND_EN
    localparam int EXP_POS = 3;
    localparam int EXP_NEG = -2;
`else
    localparam int EXP_POS = 2;
    localparam int EXP_NEG = -3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        sat_flag;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data  = v[15:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send4(input int v);
        for (int k = 0; k < 4; k++) send(v);
    endtask

    task automatic pop_check(input string tag, input int exp);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_data"}, int'($signed(out_data)), exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'($signed(out_data)), 0);
        check("rst_sat", int'(sat_flag), 0);
        check("rst_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        tick();

        // 1,2,3,4 -> 10/4
        send(1); send(2); send(3);
        check("t1_pre_valid", int'(out_valid), 0);
        send(4);
        pop_check("t1", EXP_POS);
        check("t1_empty", int'(out_valid), 0);
        check("t1_hold", int'($signed(out_data)), EXP_POS);

        // -1..-4 -> -10/4
        send(-1); send(-2); send(-3); send(-4);
        pop_check("t2", EXP_NEG);

        // gaps of 3 idle cycles inside a block
        for (int i = 0; i < 4; i++) begin
            send(4);
            if (i < 3) begin
                repeat (3) tick();
                check("t3_gap_valid", int'(out_valid), 0);
            end
        end
        pop_check("t3", 4);
        check("t3_sat", int'(sat_flag), 0);

        // saturation both ways
        send4(1000);
        pop_check("t4_pos", 127);
        check("t4_sat_pos", int'(sat_flag), 1);
        send4(-1000);
        pop_check("t4_neg", -128);
        check("t4_sat_neg", int'(sat_flag), 1);

        // backpressure: 5 dumps into a 4-deep FIFO
        for (int i = 0; i < 20; i++) send(8);
        check("t5_drop", int'(drop_cnt), 1);
        check("t5_valid", int'(out_valid), 1);
        check("t5_head", int'($signed(out_data)), 8);
        repeat (5) tick();
        check("t5_head_stable", int'($signed(out_data)), 8);
        for (int i = 0; i < 4; i++) pop_check("t5_pop", 8);
        check("t5_empty", int'(out_valid), 0);

        // full FIFO with simultaneous pop and dump
        for (int v = 1; v <= 4; v++) send4(v);
        check("t6_drop_fill", int'(drop_cnt), 1);
        send(8); send(8); send(8);
        check("t6_head", int'($signed(out_data)), 1);
        in_valid  = 1'b1;
        in_data   = 16'd8;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t6_no_drop", int'(drop_cnt), 1);
        pop_check("t6_q0", 2);
        pop_check("t6_q1", 3);
        pop_check("t6_q2", 4);
        pop_check("t6_q3", 8);
        check("t6_empty", int'(out_valid), 0);

        // reset mid-block discards the partial sum
        send(100); send(100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_rst_valid", int'(out_valid), 0);
        check("t7_rst_data", int'($signed(out_data)), 0);
        check("t7_rst_sat", int'(sat_flag), 0);
        check("t7_rst_drop", int'(drop_cnt), 0);
        send(4); send(4); send(4);
        check("t7_pre_valid", int'(out_valid), 0);
        check("t7_pre_data", int'($signed(out_data)), 0);
        send(4);
        pop_check("t7", 4);
        check("t7_empty", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 3-tap FIR filter. Consumes its 16-bit signed output stream, averages blocks of 2^DEC_LOG2 samples (integrate-and-dump), scales, and saturates to OUT_W bits.
- Buffers results in a small FIFO behind a valid/ready output handshake.
- The FIR has no backpressure, so input is never stalled. Overflowing results are dropped and counted.

Parameters:
- IN_W, 16, input sample width (matches FIR y_out)
- OUT_W, 8, output sample width
- DEC_LOG2, 2, decimation factor M = 2^DEC_LOG2 (legal 0..4)
- SCALE_SH, 0, extra arithmetic right shift after averaging (legal 0..8)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data valid this cycle
- in_data  in  IN_W  signed FIR output sample
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_W  signed decimated sample (FIFO head)
- sat_flag  out  1  sticky: any result saturated since reset
- drop_cnt  out  8  results dropped due to full FIFO, saturating at 255

Behaviour:
- Reset (synchronous, on rising clk with rst=1):
  - acc=0, phase=0, FIFO empty.
  - out_valid=0, out_data=0, sat_flag=0, drop_cnt=0.
  - rst overrides all same-cycle activity.
- Accumulator: signed, IN_W+DEC_LOG2+1 bits. phase counter is DEC_LOG2 bits.
- in_valid=1 and phase != M-1: acc <= acc+in_data; phase++.
- in_valid=1 and phase == M-1 (dump):
  - sum = acc+in_data.
  - r = sum >>> S, where S = DEC_LOG2+SCALE_SH, arithmetic shift (floor).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; if clipped, sat_flag <= 1.
  - Push the result; acc <= 0; phase <= 0.
- DEC_LOG2=0: every valid sample is a dump.
- in_valid=0: acc and phase hold. Gaps may occur anywhere within a block.
- Latency: result pushed at the dump edge; visible as out_valid=1 at the FIFO head on the following cycle if the FIFO was empty.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop and push is legal; count unchanged).
  - Otherwise the result is discarded and drop_cnt++ (saturating at 255). acc/phase still reset; the block boundary is kept.
  - out_data is the head entry when out_valid=1, and holds its last value when empty.
  - Head must remain stable while out_valid && !out_ready.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Reset mid-block discards the partial sum. The next block starts at phase 0.

Optional Feature:
- Macro: FIR_DEC_ROUND_EN.
- Defined: round half-up before the shift: r = (sum + 2^(S-1)) >>> S when S>0. No effect when S=0. Rounding add is done at the full accumulator width (guard bit prevents wrap).
- Undefined: pure truncation (floor) as above. Port list is identical either way.

Decomposition:
- Package fir_pkg holds:
  - FIR_SAMPLE_W=16
  - DEC_OUT_W=8
  - Saturation function sat_to_w(value, width)
  - Typedef fir_sample_t (signed [15:0])
- One sub-module, fir_dec_fifo: synchronous FIFO with valid/ready pop, push/full/count, simultaneous push+pop when full.
- Accumulator, phase counter, scaling and saturation stay in the top.

Test Plan:
- M=4, S=0, inputs 1,2,3,4 contiguous -> one output: 2 (truncate) or 3 (FIR_DEC_ROUND_EN); out_valid rises the cycle after the 4th sample edge.
- Inputs -1,-2,-3,-4 -> -3 (truncate) or -2 (round); inputs 4,4,4,4 with in_valid gaps of 3 cycles between samples -> 4.
- Inputs 1000 x4 -> 127, sat_flag=1; then -1000 x4 -> -128, sat_flag stays 1.
- out_ready=0, 20 samples of value 8 (5 dumps) -> 4 entries held, drop_cnt=1, head stable; then out_ready=1 -> four outputs of 8, out_valid falls.
- FIFO full plus simultaneous pop and dump in the same cycle -> no drop, count stays 4, new 8 appended.
- 2 samples of 100, rst for 1 cycle, then 4 samples of 4 -> single output 4; all outputs 0 during and after reset until the dump.
